// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: ALU control words (also used by the
// upstream decoder) and the execute-unit FSM states.
package exec_pkg;

  typedef enum logic [2:0] {
    CTRL_ADD  = 3'b000,
    CTRL_SUB  = 3'b001,
    CTRL_AND  = 3'b010,
    CTRL_OR   = 3'b011,
    CTRL_SLL  = 3'b100,
    CTRL_SRA  = 3'b101,
    CTRL_MUL  = 3'b110,
    CTRL_RSVD = 3'b111
  } ctrl_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/booth_mul_step.sv
// One radix-2 Booth step: conditionally add/subtract the multiplicand into the
// accumulator, then arithmetic-shift {acc, mq, q-1} right by one bit.
// The accumulator and multiplicand carry one extra sign bit so that the most
// negative multiplicand never overflows a partial sum.
module booth_mul_step #(
  parameter int WIDTH = 32
) (
  input  logic signed [WIDTH:0]   acc,
  input  logic signed [WIDTH:0]   mcand,
  input  logic        [WIDTH-1:0] mq,
  input  logic                    q1,
  output logic signed [WIDTH:0]   acc_nxt,
  output logic        [WIDTH-1:0] mq_nxt,
  output logic                    q1_nxt
);

  logic signed [WIDTH:0] sum;

  // Booth recoding of the bit pair {mq[0], q-1}: 01 adds, 10 subtracts.
  always_comb begin
    sum = acc;
    case ({mq[0], q1})
      2'b01:   sum = acc + mcand;
      2'b10:   sum = acc - mcand;
      default: sum = acc;
    endcase
  end

  assign acc_nxt = sum >>> 1;
  assign mq_nxt  = {sum[0], mq[WIDTH-1:1]};
  assign q1_nxt  = mq[0];

endmodule

// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU ops plus an iterative radix-2 Booth multiply,
// with valid/ready handshakes on both sides. One op in flight at a time.
module exec_unit
  import exec_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              ctrl,
  input  logic signed [WIDTH-1:0] operand_a,
  input  logic signed [WIDTH-1:0] operand_b,
  input  logic [SHW-1:0]          shamt,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] result,
  output logic                    overflow,
  output logic                    illegal,
  output logic                    busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
    return (sa != sb) && (sr != sa);
  endfunction

  // The product fits in WIDTH bits only if the upper half is pure sign extension.
  function automatic logic mul_ovf(input logic [WIDTH-1:0] hi, input logic lo_msb);
    return hi != {WIDTH{lo_msb}};
  endfunction

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic signed [WIDTH:0]   acc_q, acc_d;
  logic signed [WIDTH:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]        mq_q, mq_d;
  logic                    q1_q, q1_d;
  logic signed [WIDTH-1:0] res_d;
  logic                    ovf_d, ill_d;

  logic signed [WIDTH:0]   acc_s;
  logic [WIDTH-1:0]        mq_s;
  logic                    q1_s;

  logic signed [WIDTH-1:0] sum_a, diff_a, alu_res;
  logic                    alu_ovf;

  booth_mul_step #(.WIDTH(WIDTH)) u_step (
    .acc     (acc_q),
    .mcand   (mcand_q),
    .mq      (mq_q),
    .q1      (q1_q),
    .acc_nxt (acc_s),
    .mq_nxt  (mq_s),
    .q1_nxt  (q1_s)
  );

  assign sum_a  = operand_a + operand_b;
  assign diff_a = operand_a - operand_b;

  // Single-cycle datapath; MUL and the reserved code produce zero here.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (ctrl)
      CTRL_ADD: begin
        alu_res = sum_a;
        alu_ovf = add_ovf(operand_a[WIDTH-1], operand_b[WIDTH-1], sum_a[WIDTH-1]);
      end
      CTRL_SUB: begin
        alu_res = diff_a;
        alu_ovf = sub_ovf(operand_a[WIDTH-1], operand_b[WIDTH-1], diff_a[WIDTH-1]);
      end
      CTRL_AND: alu_res = operand_a & operand_b;
      CTRL_OR:  alu_res = operand_a | operand_b;
      CTRL_SLL: alu_res = operand_a << shamt;
      CTRL_SRA: alu_res = operand_a >>> shamt;
      default:  alu_res = '0;
    endcase
  end

  // Next-state and next-datapath logic for the IDLE/MUL/DONE sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mq_d    = mq_q;
    q1_d    = q1_q;
    res_d   = result;
    ovf_d   = overflow;
    ill_d   = illegal;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (ctrl == CTRL_MUL) begin
            mcand_d = {operand_a[WIDTH-1], operand_a};
            mq_d    = operand_b;
            q1_d    = 1'b0;
            acc_d   = '0;
            cnt_d   = CW'(WIDTH);
            state_d = ST_MUL;
          end else begin
            res_d   = alu_res;
            ovf_d   = alu_ovf;
            ill_d   = (ctrl == CTRL_RSVD);
            state_d = ST_DONE;
          end
        end
      end
      ST_MUL: begin
        acc_d = acc_s;
        mq_d  = mq_s;
        q1_d  = q1_s;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          res_d   = mq_s;
          ovf_d   = mul_ovf(acc_s[WIDTH-1:0], mq_s[WIDTH-1]);
          ill_d   = 1'b0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state and visible outputs; reset drops any in-flight op.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      result   <= '0;
      overflow <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result   <= res_d;
      overflow <= ovf_d;
      illegal  <= ill_d;
    end
  end

  // Multiplier working registers; only meaningful while in MUL.
  always_ff @(posedge clock) begin
    acc_q   <= acc_d;
    mcand_q <= mcand_d;
    mq_q    <= mq_d;
    q1_q    <= q1_d;
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_MUL);

endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: reference model + scoreboard checked every
// output-valid cycle, plus directed vectors with hand-computed expectations.
module tb_exec_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [2:0]  ctrl = 3'd0;
  logic [31:0] a = '0, b = '0;
  logic [4:0]  shamt = '0;
  logic        in_ready, out_valid, overflow, illegal, busy;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        ill;
  } exp_t;

  exp_t sb[$];

  exec_unit #(.WIDTH(32), .SHW(5)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ctrl      (ctrl),
    .operand_a (a),
    .operand_b (b),
    .shamt     (shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .illegal   (illegal),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  // Behavioural model: plain 64-bit arithmetic on the signed operands.
  function automatic exp_t model(input logic [2:0] c, input logic [31:0] oa,
                                 input logic [31:0] ob, input logic [4:0] s);
    exp_t   e;
    longint sa, sb_, r;
    sa = longint'($signed(oa));
    sb_ = longint'($signed(ob));
    r = 0;
    e.res = '0; e.ovf = 1'b0; e.ill = 1'b0;
    case (c)
      3'd0: r = sa + sb_;
      3'd1: r = sa - sb_;
      3'd2: r = longint'($signed(oa & ob));
      3'd3: r = longint'($signed(oa | ob));
      3'd4: r = longint'($signed(oa << s));
      3'd5: r = sa >>> s;
      3'd6: r = sa * sb_;
      default: begin r = 0; e.ill = 1'b1; end
    endcase
    e.res = r[31:0];
    if (c == 3'd0 || c == 3'd1 || c == 3'd6)
      e.ovf = (r != longint'($signed(r[31:0])));
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Compare DUT against the model queue whenever a result is presented, then
  // update the scoreboard just before the next rising edge.
  always @(negedge clock) begin
    #1;
    if (reset_n && out_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected out_valid: result 0x%08h with no op outstanding", result);
      end else begin
        chk("model result", result, sb[0].res);
        chk("model overflow", {31'b0, overflow}, {31'b0, sb[0].ovf});
        chk("model illegal", {31'b0, illegal}, {31'b0, sb[0].ill});
      end
    end
    #3;
    if (!reset_n) sb.delete();
    else begin
      if (out_valid && out_ready && sb.size() > 0) void'(sb.pop_front());
      if (in_valid && in_ready) sb.push_back(model(ctrl, a, b, shamt));
    end
  end

  task automatic send(input logic [2:0] c, input logic [31:0] oa, input logic [31:0] ob,
                      input logic [4:0] s);
    int n = 0;
    @(negedge clock);
    in_valid = 1'b1; ctrl = c; a = oa; b = ob; shamt = s;
    while (!in_ready && n < 100) begin @(negedge clock); n++; end
    chk("send in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat, output int bcyc);
    lat = 1; bcyc = 0;
    while (!out_valid && lat < 200) begin
      if (busy) bcyc++;
      @(negedge clock);
      lat++;
    end
    chk("out_valid timeout", {31'b0, out_valid}, 32'd1);
  endtask

  task automatic run_op(input string name, input logic [2:0] c, input logic [31:0] oa,
                        input logic [31:0] ob, input logic [4:0] s,
                        input logic [31:0] er, input logic eo, input logic ei,
                        input int elat, input int ebusy);
    int lat, bcyc;
    send(c, oa, ob, s);
    wait_out(lat, bcyc);
    chk({name, " latency"}, lat, elat);
    chk({name, " busy cycles"}, bcyc, ebusy);
    chk({name, " result"}, result, er);
    chk({name, " overflow"}, {31'b0, overflow}, {31'b0, eo});
    chk({name, " illegal"}, {31'b0, illegal}, {31'b0, ei});
    @(negedge clock);
    chk({name, " idle after"}, {30'b0, out_valid, in_ready}, 32'd1);
  endtask

  task automatic run_model(input logic [2:0] c, input logic [31:0] oa, input logic [31:0] ob,
                           input logic [4:0] s);
    int lat, bcyc;
    send(c, oa, ob, s);
    wait_out(lat, bcyc);
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    // Reset values
    repeat (3) @(negedge clock);
    chk("reset result", result, 32'd0);
    chk("reset flags", {28'b0, out_valid, busy, overflow, illegal}, 32'd0);
    chk("reset in_ready", {31'b0, in_ready}, 32'd1);
    reset_n = 1'b1;
    @(negedge clock);
    chk("post-reset in_ready", {31'b0, in_ready}, 32'd1);

    // Reset in the middle of a multiply drops it silently
    send(3'd6, 32'd5, 32'd9, 5'd0);
    repeat (9) @(negedge clock);
    chk("mid-mul busy", {31'b0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid-mul reset result", result, 32'd0);
    chk("mid-mul reset flags", {27'b0, out_valid, busy, overflow, illegal, in_ready}, 32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    cnt = 0;
    repeat (40) begin @(negedge clock); if (out_valid) cnt++; end
    chk("dropped mul out_valid pulses", cnt, 32'd0);
    chk("dropped mul in_ready", {31'b0, in_ready}, 32'd1);

    // Single-cycle ops
    run_op("ADD max+1", 3'd0, 32'h7FFFFFFF, 32'd1, 5'd0, 32'h80000000, 1'b1, 1'b0, 1, 0);
    run_op("SUB 5-7",   3'd1, 32'd5, 32'd7, 5'd0, 32'hFFFFFFFE, 1'b0, 1'b0, 1, 0);
    run_op("SLL 1<<31", 3'd4, 32'd1, 32'hDEAD, 5'd31, 32'h80000000, 1'b0, 1'b0, 1, 0);
    run_op("SRA",       3'd5, 32'h80000000, 32'd0, 5'd4, 32'hF8000000, 1'b0, 1'b0, 1, 0);
    run_op("AND",       3'd2, 32'hF0F0, 32'hFF00, 5'd0, 32'h0000F000, 1'b0, 1'b0, 1, 0);
    run_op("OR",        3'd3, 32'hF0F0, 32'hFF00, 5'd0, 32'h0000FFF0, 1'b0, 1'b0, 1, 0);

    // Multiplies
    run_op("MUL -3*7",    3'd6, 32'hFFFFFFFD, 32'd7, 5'd0, 32'hFFFFFFEB, 1'b0, 1'b0, 33, 32);
    run_op("MUL 2^16^2",  3'd6, 32'h00010000, 32'h00010000, 5'd0, 32'd0, 1'b1, 1'b0, 33, 32);
    run_op("MUL min*-1",  3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd0, 32'h80000000, 1'b1, 1'b0, 33, 32);

    // Backpressure: result frozen, new requests ignored
    out_ready = 1'b0;
    send(3'd0, 32'd2, 32'd3, 5'd0);
    for (int i = 0; i < 5; i++) begin
      chk("stall result", result, 32'd5);
      chk("stall valid/ready", {30'b0, out_valid, in_ready}, 32'd2);
      in_valid = i[0]; ctrl = 3'd0; a = 32'd100 + i; b = 32'd7;
      @(negedge clock);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    chk("stall release idle", {30'b0, out_valid, in_ready}, 32'd1);

    // Reserved control word, then an ADD clears illegal
    run_op("RSVD", 3'd7, 32'hFFFF, 32'hFFFF, 5'd0, 32'd0, 1'b0, 1'b1, 1, 0);
    run_op("ADD after RSVD", 3'd0, 32'd10, 32'hFFFFFFFF, 5'd0, 32'd9, 1'b0, 1'b0, 1, 0);

    // Additional vectors checked against the model only
    run_model(3'd1, 32'h80000000, 32'd1, 5'd0);
    run_model(3'd0, 32'h80000000, 32'h80000000, 5'd0);
    run_model(3'd6, 32'h80000000, 32'h80000000, 5'd0);
    run_model(3'd6, 32'd12345, 32'hFFFFFD5A, 5'd0);
    run_model(3'd6, 32'h7FFFFFFF, 32'h7FFFFFFF, 5'd0);
    run_model(3'd6, 32'd0, 32'h80000000, 5'd0);
    run_model(3'd4, 32'hFFFFFFFF, 32'd0, 5'd5);
    run_model(3'd5, 32'h7000000F, 32'd0, 5'd0);
    run_model(3'd5, 32'hC0000000, 32'd0, 5'd31);

    repeat (3) @(negedge clock);
    chk("scoreboard drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/exec_unit.md
Name: exec_unit

Overview:
- Execute stage directly downstream of the opcode-to-ALU-control decoder; consumes its 3-bit ctrl word plus two operands and produces a registered result.
- Single-cycle ops (add/sub/and/or/shift) complete in one cycle after accept; MUL runs an iterative radix-2 Booth sequence.
- Valid/ready handshake on both sides so the pipeline stalls cleanly during multi-cycle ops.

Parameters:
- WIDTH, 32, operand/result width in bits (at least 4; even).
- SHW, 5, shift-amount width; clog2(WIDTH).

Ports:
- clock  in  1  single design clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream presents ctrl/operands.
- in_ready  out  1  unit can accept; transfer when in_valid && in_ready.
- ctrl  in  3  ALU control word: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLL, 101 SRA, 110 MUL, 111 reserved.
- operand_a  in  WIDTH  signed operand A.
- operand_b  in  WIDTH  signed operand B.
- shamt  in  SHW  shift amount for SLL/SRA.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  downstream accepts; transfer when out_valid && out_ready.
- result  out  WIDTH  registered result.
- overflow  out  1  signed overflow (ADD/SUB/MUL).
- illegal  out  1  ctrl was 111.
- busy  out  1  MUL iteration in progress.

Behaviour:
- Reset (async assert, sync deassert at the boundary): state=IDLE; result=0, overflow=0, illegal=0, out_valid=0, busy=0; in_ready=1 once reset_n is high.
- FSM states are IDLE, MUL, DONE.
- in_ready = (state==IDLE). It is combinational from state only and has no path from in_valid.
- IDLE, accept, ctrl!=110: compute combinationally and register result/flags; go to DONE. Latency is 1 cycle (out_valid high the cycle after accept).
- IDLE, accept, ctrl==110: latch A (multiplicand), B (multiplier) and a count equal to WIDTH; clear the accumulator; busy=1; go to MUL.
- MUL: one Booth step per cycle over the {acc, B, q-1} pair with an arithmetic right shift. After WIDTH steps, result = low WIDTH bits of the 2*WIDTH signed product, and overflow=1 if the upper WIDTH bits are not the sign extension of result[WIDTH-1]. Then busy=0 and go to DONE. Accept-to-out_valid latency is WIDTH+1 cycles.
- DONE: hold result/flags stable while out_valid=1. When out_ready=1, clear out_valid and go to IDLE. No new accept occurs in the same cycle, so peak throughput is 1 op per 2 cycles.
- ADD/SUB: modulo 2^WIDTH. Overflow = operands' sign condition (same signs for ADD, differing signs for SUB) and result sign differs from A.
- AND/OR/SLL/SRA: overflow=0. SLL fills zeros; SRA replicates A's MSB. Shift uses shamt only; operand_b is ignored.
- MUL -2^(WIDTH-1) * -1: result=-2^(WIDTH-1), overflow=1.
- ctrl 111: result=0, overflow=0, illegal=1, 1-cycle latency. illegal=0 for all other ops.
- Inputs change while not accepted: ignored. Operands are sampled only at accept.
- out_ready held high in DONE: single-cycle completion. out_ready low: unbounded stall, with outputs frozen.
- Reset mid-MUL or mid-DONE: immediate return to reset values. The in-flight op is dropped with no output.

Decomposition:
- Shared package (exec_pkg):
  - ctrl encodings CTRL_ADD..CTRL_RSVD, which the upstream decoder also uses.
  - state encodings ST_IDLE/ST_MUL/ST_DONE.
- One sub-module: booth_mul_step (combinational single Booth step: acc/multiplier/q-1 in, shifted triple out), instantiated once and iterated by the FSM.
- Single-cycle datapath stays inline.

Test Plan:
- Reset during MUL at cycle 10 -> all outputs 0 and in_ready=1 after release; no out_valid pulse.
- ADD 0x7FFFFFFF + 1, out_ready=1 -> one cycle later out_valid=1, result=0x80000000, overflow=1; SUB 5-7 -> 0xFFFFFFFE, overflow=0.
- SLL 0x1 by 31 -> 0x80000000; SRA 0x80000000 by 4 -> 0xF8000000; AND/OR 0xF0F0,0xFF00 -> 0xF000/0xFFF0.
- MUL -3 * 7 -> busy 32 cycles, out_valid at accept+33, result=0xFFFFFFEB, overflow=0. MUL 0x10000*0x10000 -> result 0, overflow=1. MUL 0x80000000 * -1 -> 0x80000000, overflow=1.
- Backpressure: out_ready=0 for 5 cycles after ADD 2+3 -> result stays 5, in_ready=0; in_valid toggling with new operands is ignored. out_ready=1 -> IDLE next cycle.
- ctrl=111 with A=B=0xFFFF -> result=0, illegal=1, overflow=0. Following ADD clears illegal.
